// File: rtl/core_bus_pkg.sv
// Shared types for the 2:1 Avalon-MM arbiter: port IDs, grant states, default read depth.
package core_bus_pkg;

  localparam int MAX_PENDING_DEF = 4;

  typedef logic port_id_t;

  typedef enum logic {
    G0 = 1'b0,
    G1 = 1'b1
  } grant_e;

endpackage

// File: rtl/avl_arb_id_fifo.sv
// In-order FIFO of port IDs for outstanding reads; head is visible combinationally.
// Pushes while full and pops while empty are dropped, so a same-cycle push never feeds its own pop.
module avl_arb_id_fifo
  import core_bus_pkg::*;
#(
  parameter int DEPTH = MAX_PENDING_DEF
) (
  input  logic     clk,
  input  logic     rest,
  input  logic     i_push,
  input  logic     i_pop,
  input  port_id_t i_din,
  output port_id_t o_dout,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  port_id_t       r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers are AW bits wide, so wrap at DEPTH falls out of the power-of-two width.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/avl_arb_2to1.sv
// Round-robin 2:1 Avalon-MM arbiter: owner's command passes through with zero latency,
// non-owner is stalled, reads beyond MAX_PENDING stall, responses steered by an in-order ID FIFO.
module avl_arb_2to1
  import core_bus_pkg::*;
#(
  parameter int MAX_PENDING = MAX_PENDING_DEF
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] i_avl_s0_address,
  input  logic [3:0]  i_avl_s0_byte_en,
  input  logic        i_avl_s0_read,
  input  logic        i_avl_s0_write,
  input  logic [31:0] i_avl_s0_write_data,
  output logic [31:0] o_avl_s0_read_data,
  output logic        o_avl_s0_read_data_valid,
  output logic        o_avl_s0_waitrequest,
  input  logic [31:0] i_avl_s1_address,
  input  logic [3:0]  i_avl_s1_byte_en,
  input  logic        i_avl_s1_read,
  input  logic        i_avl_s1_write,
  input  logic [31:0] i_avl_s1_write_data,
  output logic [31:0] o_avl_s1_read_data,
  output logic        o_avl_s1_read_data_valid,
  output logic        o_avl_s1_waitrequest,
  output logic [31:0] o_avl_m_address,
  output logic [3:0]  o_avl_m_byte_en,
  output logic        o_avl_m_read,
  output logic        o_avl_m_write,
  output logic [31:0] o_avl_m_write_data,
  input  logic [31:0] i_avl_m_read_data,
  input  logic        i_avl_m_read_data_valid,
  input  logic        i_avl_m_waitrequest
);

  grant_e      r_grant;
  grant_e      w_grant_nxt;
  logic        r_served;
  logic        w_served_nxt;
  logic [31:0] w_own_addr;
  logic [31:0] w_own_wdata;
  logic [3:0]  w_own_be;
  logic        w_own_rd;
  logic        w_own_wr;
  logic        w_oth_req;
  logic        w_own_cmd;
  logic        w_rd_block;
  logic        w_own_wait;
  logic        w_acc;
  logic        w_stall;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_rsp;
  port_id_t    w_head;

  always_comb begin
    w_own_addr  = i_avl_s0_address;
    w_own_be    = i_avl_s0_byte_en;
    w_own_rd    = i_avl_s0_read;
    w_own_wr    = i_avl_s0_write;
    w_own_wdata = i_avl_s0_write_data;
    w_oth_req   = i_avl_s1_read | i_avl_s1_write;
    if (r_grant == G1) begin
      w_own_addr  = i_avl_s1_address;
      w_own_be    = i_avl_s1_byte_en;
      w_own_rd    = i_avl_s1_read;
      w_own_wr    = i_avl_s1_write;
      w_own_wdata = i_avl_s1_write_data;
      w_oth_req   = i_avl_s0_read | i_avl_s0_write;
    end
  end

  // A full ID FIFO stalls reads even on a popping cycle; the read is also hidden from memory.
  assign w_own_cmd  = w_own_rd | w_own_wr;
  assign w_rd_block = w_own_rd & w_fifo_full;
  assign w_own_wait = i_avl_m_waitrequest | w_rd_block;
  assign w_acc      = w_own_cmd & ~w_own_wait;
  assign w_stall    = w_own_cmd & w_own_wait;

  assign o_avl_m_address    = w_own_addr;
  assign o_avl_m_byte_en    = w_own_be;
  assign o_avl_m_write_data = w_own_wdata;
  assign o_avl_m_read       = w_own_rd & ~w_rd_block & rest;
  assign o_avl_m_write      = w_own_wr & rest;

  assign o_avl_s0_waitrequest = (r_grant == G0) ? w_own_wait : 1'b1;
  assign o_avl_s1_waitrequest = (r_grant == G1) ? w_own_wait : 1'b1;

  // Hand over only when the owner is not mid-stall and has either gone idle or been served once.
  always_comb begin
    w_grant_nxt  = r_grant;
    w_served_nxt = r_served | w_acc;
    if (!w_stall && w_oth_req && (!w_own_cmd || r_served || w_acc)) begin
      w_grant_nxt  = (r_grant == G0) ? G1 : G0;
      w_served_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_grant  <= G0;
      r_served <= 1'b0;
    end else begin
      r_grant  <= w_grant_nxt;
      r_served <= w_served_nxt;
    end
  end

  avl_arb_id_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_id_fifo (
    .clk     (clk),
    .rest    (rest),
    .i_push  (w_acc & w_own_rd),
    .i_pop   (i_avl_m_read_data_valid),
    .i_din   (r_grant == G1),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Responses with nothing outstanding (e.g. orphaned by a reset) are dropped.
  assign w_rsp = i_avl_m_read_data_valid & ~w_fifo_empty & rest;

  assign o_avl_s0_read_data       = i_avl_m_read_data;
  assign o_avl_s1_read_data       = i_avl_m_read_data;
  assign o_avl_s0_read_data_valid = w_rsp & (w_head == 1'b0);
  assign o_avl_s1_read_data_valid = w_rsp & (w_head == 1'b1);

endmodule
